// File: rtl/exe_if.sv
// exe_if: operand/result bundle for the execute stage.
//   master : side that supplies inst/dataA/dataB and observes the registered results
//   slave  : the execute stage itself
// Signals:
//   inst      IW  instruction entering execute
//   dataA     DW  operand A (rs1 value)
//   dataB     DW  operand B (rs2 value)
//   inst_o    IW  registered copy of inst
//   data_out  DW  registered ALU result
//   zero      1   registered result-is-zero flag (only with EXE_ZERO_FLAG_EN)
interface exe_if #(
  parameter int DW = 32,
  parameter int IW = 32
);
  logic [IW-1:0] inst;
  logic [DW-1:0] dataA;
  logic [DW-1:0] dataB;
  logic [IW-1:0] inst_o;
  logic [DW-1:0] data_out;
`ifdef EXE_ZERO_FLAG_EN
  logic          zero;
`endif

  modport master (
    output inst, dataA, dataB,
`ifdef EXE_ZERO_FLAG_EN
    input  zero,
`endif
    input  inst_o, data_out
  );

  modport slave (
    input  inst, dataA, dataB,
`ifdef EXE_ZERO_FLAG_EN
    output zero,
`endif
    output inst_o, data_out
  );
endinterface

// File: rtl/exe.sv
// exe: execute stage of the pipelined core.
// Decodes op/isel from the instruction, selects operand B (register or
// sign-extended immediate), evaluates the 16-entry ALU and registers the
// result plus the instruction for MEM/WB. Latency 1, throughput 1/cycle,
// no stalls.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; outputs become a NOP (all zero)
//   bus  : exe_if.slave (inst, dataA, dataB in; inst_o, data_out[, zero] out)
// Optional feature: define EXE_ZERO_FLAG_EN to add the registered `zero`
// flag (1 when the ALU result is all zeros, resets to 1).
// Instruction layout (LSB up): op[IMW] | isel | rd[RFW] | rs1[RFW] | rs2[RFW] | imm
module exe #(
  parameter int RFW = 5,
  parameter int IMW = 4,
  parameter int DW  = 32,
  parameter int IW  = 32
) (
  input  logic   clk,
  input  logic   rst,
  exe_if.slave   bus
);
  localparam int IMM_LSB = IMW + 1 + 3*RFW;
  localparam int IMMW    = IW - IMM_LSB;
  localparam int SHW     = $clog2(DW);

  typedef enum logic [IMW-1:0] {
    OP_ADD   = IMW'(0),
    OP_SUB   = IMW'(1),
    OP_AND   = IMW'(2),
    OP_OR    = IMW'(3),
    OP_XOR   = IMW'(4),
    OP_SLL   = IMW'(5),
    OP_SRL   = IMW'(6),
    OP_SRA   = IMW'(7),
    OP_SLT   = IMW'(8),
    OP_SLTU  = IMW'(9),
    OP_PASSA = IMW'(10),
    OP_PASSB = IMW'(11),
    OP_NOR   = IMW'(12),
    OP_SEQ   = IMW'(13),
    OP_SNE   = IMW'(14)
  } alu_op_e;

  // Decoded view of the instruction; register specifiers are not needed here,
  // they only ride along in inst_o.
  typedef struct packed {
    logic [IMW-1:0]  op;
    logic            isel;
    logic [IMMW-1:0] imm;
  } dec_t;

  dec_t          dec;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic [SHW-1:0] shamt;
  logic [DW-1:0] res;

  always_comb begin
    dec.op   = bus.inst[IMW-1:0];
    dec.isel = bus.inst[IMW];
    dec.imm  = bus.inst[IW-1:IMM_LSB];
  end

  assign opa   = bus.dataA;
  assign opb   = dec.isel ? {{(DW-IMMW){dec.imm[IMMW-1]}}, dec.imm} : bus.dataB;
  // Only the low log2(DW) bits of B steer the shifter.
  assign shamt = opb[SHW-1:0];

  always_comb begin
    res = '0;
    case (dec.op)
      OP_ADD:   res = opa + opb;
      OP_SUB:   res = opa - opb;
      OP_AND:   res = opa & opb;
      OP_OR:    res = opa | opb;
      OP_XOR:   res = opa ^ opb;
      OP_SLL:   res = opa << shamt;
      OP_SRL:   res = opa >> shamt;
      OP_SRA:   res = $signed(opa) >>> shamt;
      OP_SLT:   res = {{(DW-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_SLTU:  res = {{(DW-1){1'b0}}, (opa < opb)};
      OP_PASSA: res = opa;
      OP_PASSB: res = opb;
      OP_NOR:   res = ~(opa | opb);
      OP_SEQ:   res = {{(DW-1){1'b0}}, (opa == opb)};
      OP_SNE:   res = {{(DW-1){1'b0}}, (opa != opb)};
      default:  res = '0;  // op 15 reserved
    endcase
  end

  // Reset forces a NOP into the output register and drops whatever was sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out <= '0;
      bus.inst_o   <= '0;
    end else begin
      bus.data_out <= res;
      bus.inst_o   <= bus.inst;
    end
  end

`ifdef EXE_ZERO_FLAG_EN
  // A zero result register holds 0 after reset, so the flag resets to 1.
  always_ff @(posedge clk) begin
    if (rst) bus.zero <= 1'b1;
    else     bus.zero <= (res == '0);
  end
`endif
endmodule

// File: tb/tb_exe.sv
// tb_exe: scoreboard bench for exe. The driver pushes the expected registered
// outputs (from a plain-arithmetic reference model) when it applies inputs;
// an independent monitor pops one entry after each rising edge and compares.
module tb_exe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_if #(.DW(32), .IW(32)) bus ();

  exe #(.RFW(5), .IMW(4), .DW(32), .IW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] data;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  localparam longint P = 64'h1_0000_0000;

  function automatic longint to_signed(input longint u);
    return (u >= 64'h8000_0000) ? u - P : u;
  endfunction

  // Reference model: evaluates the ALU rules with 64-bit integer arithmetic.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint ua, sa, ub, sb, imm, d, q, r;
    int     sh;
    ua  = longint'(a);
    sa  = to_signed(ua);
    imm = longint'(i[31:20]);
    if (imm >= 2048) imm = imm - 4096;
    if (i[4]) begin
      sb = imm;
      ub = (imm < 0) ? imm + P : imm;
    end else begin
      ub = longint'(b);
      sb = to_signed(ub);
    end
    sh = int'(ub % 32);
    d  = longint'(1) << sh;
    case (i[3:0])
      4'd0:  r = (ua + ub) % P;
      4'd1:  r = (ua - ub + P) % P;
      4'd2:  r = ua & ub;
      4'd3:  r = ua | ub;
      4'd4:  r = ua ^ ub;
      4'd5:  r = (ua * d) % P;
      4'd6:  r = ua / d;
      4'd7: begin
        q = sa / d;
        if (sa < 0 && (sa % d) != 0) q = q - 1;
        r = (q < 0) ? q + P : q;
      end
      4'd8:  r = (sa < sb) ? 1 : 0;
      4'd9:  r = (ua < ub) ? 1 : 0;
      4'd10: r = ua;
      4'd11: r = ub;
      4'd12: r = (P - 1) - (ua | ub);
      4'd13: r = (ua == ub) ? 1 : 0;
      4'd14: r = (ua != ub) ? 1 : 0;
      default: r = 0;
    endcase
    e.inst = i;
    e.data = r[31:0];
    e.zero = (r == 0);
    return e;
  endfunction

  function automatic logic [31:0] mk(input int op, input bit isel, input int imm);
    logic [14:0] regs;
    regs = 15'($urandom);
    return {imm[11:0], regs, isel, op[3:0]};
  endfunction

  // Apply one cycle of inputs and record what must appear after the next edge.
  task automatic drive(input logic r, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    rst       = r;
    bus.inst  = i;
    bus.dataA = a;
    bus.dataB = b;
    if (r) begin
      e.inst = '0; e.data = '0; e.zero = 1'b1;
    end else begin
      e = model(i, a, b);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: output is presented every cycle, so each edge retires one entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (bus.data_out !== e.data) begin
          fails++;
          $display("FAIL data_out inst=%h got=%h exp=%h", e.inst, bus.data_out, e.data);
        end
        tests++;
        if (bus.inst_o !== e.inst) begin
          fails++;
          $display("FAIL inst_o got=%h exp=%h", bus.inst_o, e.inst);
        end
`ifdef EXE_ZERO_FLAG_EN
        tests++;
        if (bus.zero !== e.zero) begin
          fails++;
          $display("FAIL zero inst=%h got=%b exp=%b", e.inst, bus.zero, e.zero);
        end
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] i, a, b;
    bus.inst  = '0;
    bus.dataA = '0;
    bus.dataB = '0;

    // Reset held two cycles with random inputs.
    drive(1'b1, $urandom, $urandom, $urandom);
    drive(1'b1, $urandom, $urandom, $urandom);

    // Directed cases.
    drive(1'b0, 32'h8e7425b7, 32'd445, 32'd1);                 // SRA imm -> 3
    drive(1'b0, mk(0, 1'b0, 0), 32'hFFFF_FFFF, 32'd1);         // ADD wrap -> 0
    drive(1'b0, mk(1, 1'b0, 0), 32'd0, 32'd1);                 // SUB wrap -> all ones
    drive(1'b0, mk(8, 1'b0, 0), 32'hFFFF_FFFF, 32'd1);         // SLT -> 1
    drive(1'b0, mk(9, 1'b0, 0), 32'hFFFF_FFFF, 32'd1);         // SLTU -> 0
    drive(1'b0, mk(5, 1'b0, 0), 32'd1, 32'h0000_0024);         // SLL uses B[4:0] -> 16
    drive(1'b0, mk(7, 1'b0, 0), 32'h8000_0000, 32'd31);        // SRA full -> all ones
    drive(1'b0, mk(13, 1'b0, 0), 32'h1234_5678, 32'h1234_5678); // SEQ -> 1
    drive(1'b0, mk(15, 1'b0, 0), 32'hDEAD_BEEF, 32'h1);        // reserved -> 0
    drive(1'b0, mk(11, 1'b1, 12'h7FF), 32'h0, 32'h0);          // PASSB imm +2047

    // Back-to-back, reset on the third cycle replaces that result.
    drive(1'b0, mk(0, 1'b0, 0), 32'd10, 32'd20);
    drive(1'b0, mk(4, 1'b1, 12'h800), 32'h0F0F_0F0F, 32'd0);
    drive(1'b1, mk(3, 1'b0, 0), 32'hAAAA_0000, 32'h0000_5555);
    drive(1'b0, mk(12, 1'b0, 0), 32'hF0F0_F0F0, 32'h0F0F_0000);
    drive(1'b0, mk(10, 1'b0, 0), 32'h7777_7777, 32'd3);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      i = $urandom;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = {28'd0, 4'($urandom)};
      drive(($urandom_range(0, 29) == 0), i, a, b);
    end

    // Drain.
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
